allpass_coef_loader: RTL and testbench



---
 rtl/allpass_coef_loader_if.sv | 9 +
 rtl/allpass_coef_loader.sv | 108 ++++++++++
 tb/tb_allpass_coef_loader.sv | 136 +++++++++++++
 3 files changed

// File: rtl/allpass_coef_loader_if.sv
// allpass_coef_loader_if: valid/ready coefficient word stream feeding the all-pass coefficient loader.
interface allpass_coef_loader_if #(parameter int WIDTH = 16);
  logic             s_valid;
  logic             s_ready;
  logic [WIDTH-1:0] s_data;
  logic             s_last;
  modport master (output s_valid, s_data, s_last, input s_ready);
  modport slave  (input s_valid, s_data, s_last, output s_ready);
endinterface

// File: rtl/allpass_coef_loader.sv
// allpass_coef_loader: loads N-1 coefficient words into a shadow bank, swaps to the active bank on sample_en.
// Optional saturation of incoming words is enabled by defining ALLPASS_COEF_CLAMP_EN.
module allpass_coef_loader #(
  parameter int WIDTH      = 16,
  parameter int FIXEDPOINT = 14,
  parameter int N          = 5
) (
  input  logic                     clk,
  input  logic                     rst_n,
  allpass_coef_loader_if.slave     s,
  input  logic                     sample_en,
  output logic [WIDTH*(N-1)-1:0]   c,
  output logic                     pending,
  output logic                     upd,
  output logic                     err,
  output logic                     clip
);
  localparam int IW = ($clog2(N-1) < 1) ? 1 : $clog2(N-1);
  localparam logic [IW-1:0] IDX_LAST = IW'(N-2);
  typedef enum logic [1:0] {IDLE, LOAD, DRAIN, PENDING} state_t;
  state_t                 state_q, state_d;
  logic [IW-1:0]          idx_q, idx_d;
  logic [WIDTH*(N-1)-1:0] shadow_q, shadow_d, c_q, c_d;
  logic                   s_ready_q, s_ready_d;
  logic                   pending_q, pending_d, upd_q, upd_d, err_q, err_d, clip_q, clip_d;
  logic [WIDTH-1:0]       word;
  logic                   sat;
  logic                   acc;
`ifdef ALLPASS_COEF_CLAMP_EN
  localparam logic signed [WIDTH-1:0] MAXV = WIDTH'((1 << (FIXEDPOINT-1)) - 1);
  localparam logic signed [WIDTH-1:0] MINV = -MAXV;
  always_comb word = ($signed(s.s_data) > MAXV) ? MAXV : ($signed(s.s_data) < MINV) ? MINV : s.s_data;
  assign sat = (word != s.s_data);
`else
  assign word = s.s_data;
  assign sat  = 1'b0;
`endif
  assign acc = s.s_valid && s_ready_q;
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    shadow_d  = shadow_q;
    c_d       = c_q;
    pending_d = pending_q;
    upd_d     = 1'b0;
    err_d     = 1'b0;
    clip_d    = clip_q | (acc & sat);
    case (state_q)
      IDLE: if (acc) begin
        shadow_d[WIDTH-1:0] = word;
        idx_d   = s.s_last ? '0 : IW'(1);
        err_d   = s.s_last;
        state_d = s.s_last ? IDLE : LOAD;
      end
      LOAD: if (acc) begin
        shadow_d[WIDTH*idx_q +: WIDTH] = word;
        if (idx_q == IDX_LAST) begin
          idx_d     = '0;
          pending_d = s.s_last;
          err_d     = !s.s_last;
          state_d   = s.s_last ? PENDING : DRAIN;
        end else begin
          idx_d   = s.s_last ? '0 : idx_q + IW'(1);
          err_d   = s.s_last;
          state_d = s.s_last ? IDLE : LOAD;
        end
      end
      DRAIN: if (acc && s.s_last) state_d = IDLE;
      PENDING: if (sample_en) begin
        c_d       = shadow_q;
        upd_d     = 1'b1;
        pending_d = 1'b0;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
    s_ready_d = (state_d != PENDING);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      shadow_q  <= '0;
      c_q       <= '0;
      s_ready_q <= 1'b1;
      pending_q <= 1'b0;
      upd_q     <= 1'b0;
      err_q     <= 1'b0;
      clip_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      shadow_q  <= shadow_d;
      c_q       <= c_d;
      s_ready_q <= s_ready_d;
      pending_q <= pending_d;
      upd_q     <= upd_d;
      err_q     <= err_d;
      clip_q    <= clip_d;
    end
  end
  assign s.s_ready = s_ready_q;
  assign c         = c_q;
  assign pending   = pending_q;
  assign upd       = upd_q;
  assign err       = err_q;
  assign clip      = clip_q;
endmodule

// File: tb/tb_allpass_coef_loader.sv
// tb_allpass_coef_loader: directed frames; a monitor checks c on every upd/err pulse against queued expectations.
module tb_allpass_coef_loader;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        sample_en = 1'b0;
  logic [63:0] c;
  logic        pending, upd, err, clip;
  int          total = 0;
  int          passed = 0;
  logic [63:0] exp_upd[$];
  logic [63:0] exp_err[$];
  localparam logic [63:0] FA = 64'h0400_F800_0800_1000;
  localparam logic [63:0] FB = 64'h0004_0003_0002_0001;
  localparam logic [63:0] FC = 64'h0400_0300_0200_0100;
`ifdef ALLPASS_COEF_CLAMP_EN
  localparam logic [63:0] FD = 64'h1FFF_1000_E001_1FFF;
  localparam logic        CLIP_EXP = 1'b1;
`else
  localparam logic [63:0] FD = 64'h1FFF_1000_8000_7FFF;
  localparam logic        CLIP_EXP = 1'b0;
`endif
  allpass_coef_loader_if #(.WIDTH(16)) bus ();
  allpass_coef_loader #(.WIDTH(16), .FIXEDPOINT(14), .N(5)) dut (
    .clk(clk), .rst_n(rst_n), .s(bus.slave), .sample_en(sample_en),
    .c(c), .pending(pending), .upd(upd), .err(err), .clip(clip)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask
  always @(negedge clk) if (rst_n) begin
    if (upd) begin
      if (exp_upd.size() == 0) chk("upd_unexpected", 64'(upd), 64'd0);
      else chk("upd_c", c, exp_upd.pop_front());
    end
    if (err) begin
      if (exp_err.size() == 0) chk("err_unexpected", 64'(err), 64'd0);
      else chk("err_c", c, exp_err.pop_front());
    end
  end
  task automatic send(input logic [15:0] d, input logic l, input logic se);
    int n = 0;
    @(negedge clk);
    bus.s_valid = 1'b1; bus.s_data = d; bus.s_last = l; sample_en = se;
    while (!bus.s_ready && n < 50) begin @(negedge clk); n++; end
    if (n >= 50) chk("ready_timeout", 64'(bus.s_ready), 64'd1);
    @(posedge clk); #1;
    bus.s_valid = 1'b0; bus.s_last = 1'b0; sample_en = 1'b0;
  endtask
  task automatic pulse_se();
    @(negedge clk); sample_en = 1'b1;
    @(posedge clk); #1 sample_en = 1'b0;
  endtask
  task automatic frame(input logic [63:0] f);
    for (int k = 0; k < 4; k++) send(f[16*k +: 16], k == 3, 1'b0);
  endtask
  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end
  initial begin
    bus.s_valid = 1'b0; bus.s_data = '0; bus.s_last = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    chk("rst_c", c, 64'd0);
    chk("rst_ready", 64'(bus.s_ready), 64'd1);
    chk("rst_pending", 64'(pending), 64'd0);
    chk("rst_clip", 64'(clip), 64'd0);
    send(16'h0111, 1'b0, 1'b0);
    send(16'h0222, 1'b0, 1'b0);
    @(negedge clk); rst_n = 1'b0; #1;
    chk("midrst_c", c, 64'd0);
    chk("midrst_ready", 64'(bus.s_ready), 64'd1);
    @(negedge clk); rst_n = 1'b1;
    frame(FA);
    @(negedge clk);
    chk("a_ready_low", 64'(bus.s_ready), 64'd0);
    repeat (5) begin chk("a_pending", 64'(pending), 64'd1); @(negedge clk); end
    chk("a_c_held", c, 64'd0);
    exp_upd.push_back(FA);
    pulse_se();
    @(negedge clk);
    chk("a_pending_clr", 64'(pending), 64'd0);
    chk("a_ready_back", 64'(bus.s_ready), 64'd1);
    exp_err.push_back(FA);
    send(16'h0111, 1'b0, 1'b0);
    send(16'h0222, 1'b0, 1'b0);
    send(16'h0333, 1'b1, 1'b0);
    exp_err.push_back(FA);
    send(16'h0555, 1'b1, 1'b0);
    @(negedge clk);
    chk("short_pending", 64'(pending), 64'd0);
    frame(FB);
    exp_upd.push_back(FB);
    pulse_se();
    send(16'h0AA1, 1'b0, 1'b0);
    send(16'h0AA2, 1'b0, 1'b0);
    send(16'h0AA3, 1'b0, 1'b0);
    exp_err.push_back(FB);
    send(16'h0AA4, 1'b0, 1'b0);
    send(16'h0AA5, 1'b0, 1'b0);
    send(16'h0AA6, 1'b1, 1'b0);
    @(negedge clk);
    chk("long_pending", 64'(pending), 64'd0);
    chk("long_ready", 64'(bus.s_ready), 64'd1);
    pulse_se();
    repeat (2) @(negedge clk);
    chk("long_c_held", c, FB);
    send(16'h0100, 1'b0, 1'b0);
    send(16'h0200, 1'b0, 1'b0);
    send(16'h0300, 1'b0, 1'b0);
    send(16'h0400, 1'b1, 1'b1);
    @(negedge clk);
    chk("coinc_upd", 64'(upd), 64'd0);
    chk("coinc_c", c, FB);
    chk("coinc_pending", 64'(pending), 64'd1);
    @(negedge clk);
    exp_upd.push_back(FC);
    pulse_se();
    @(negedge clk);
    chk("pre_clip", 64'(clip), 64'd0);
    frame(64'h1FFF_1000_8000_7FFF);
    exp_upd.push_back(FD);
    pulse_se();
    repeat (3) @(negedge clk);
    chk("clip", 64'(clip), 64'(CLIP_EXP));
    chk("final_c", c, FD);
    chk("upd_queue_empty", 64'(exp_upd.size()), 64'd0);
    chk("err_queue_empty", 64'(exp_err.size()), 64'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
